// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - two-requester WIDTH-bit adder built on one shared 4-bit slice
// Operations run LSB nibble first, one nibble per clock, with a registered inter-nibble carry.

module nibble_add_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             carry_q;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic             grant_any;
  logic             grant_id;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_ci;
  logic             slice_co;

  // Round-robin: on a tie the requester that did not win last time is served.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any & grant_id;

  assign slice_a  = 4'(a_q >> {cnt, 2'b00});
  assign slice_b  = 4'(b_q >> {cnt, 2'b00});
  assign slice_ci = (cnt == '0) ? cin_q : carry_q;

  nibble_add_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (slice_ci),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
      cnt        <= '0;
      carry_q    <= 1'b0;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q        <= grant_id ? req1_a : req0_a;
            b_q        <= grant_id ? req1_b : req0_b;
            cin_q      <= grant_id ? req1_cin : req0_cin;
            res_id     <= grant_id;
            last_grant <= grant_id;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          res_sum[{cnt, 2'b00} +: 4] <= slice_s;
          carry_q                    <= slice_co;
          if (cnt == CNT_LAST) begin
            res_cout  <= slice_co;
            res_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed bench for nibble_serial_add_ctrl (WIDTH 16 and 8)

module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id;
  logic [15:0] res_sum;

  logic        e0_valid, e0_ready, e0_cin;
  logic [7:0]  e0_a, e0_b;
  logic        e1_valid, e1_ready, e1_cin;
  logic [7:0]  e1_a, e1_b;
  logic        e_res_valid, e_res_ready, e_res_cout, e_res_id;
  logic [7:0]  e_res_sum;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
  );

  nibble_serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(e0_valid), .req0_ready(e0_ready), .req0_a(e0_a), .req0_b(e0_b), .req0_cin(e0_cin),
    .req1_valid(e1_valid), .req1_ready(e1_ready), .req1_a(e1_a), .req1_b(e1_b), .req1_cin(e1_cin),
    .res_valid(e_res_valid), .res_ready(e_res_ready), .res_sum(e_res_sum), .res_cout(e_res_cout), .res_id(e_res_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input string tag, input int bound);
    int n = 0;
    while (res_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_res_valid_timeout"}, res_valid, 1);
  endtask

  task automatic take_result(input string tag, input logic [15:0] es, input logic ec, input logic eid);
    wait_res(tag, 20);
    chk({tag, "_sum"}, res_sum, es);
    chk({tag, "_cout"}, res_cout, ec);
    chk({tag, "_id"}, res_id, eid);
    res_ready = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, res_valid, 0);
  endtask

  initial begin
    int  grants;
    int  gseq [4];
    int  done6;
    logic       acc0, acc1;
    logic [8:0] e_exp;
    logic       e_exp_id;

    rst_n = 1'b0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    res_ready = 0;
    e0_valid = 0; e0_a = '0; e0_b = '0; e0_cin = 0;
    e1_valid = 0; e1_a = '0; e1_b = '0; e1_cin = 0;
    e_res_ready = 0;
    tick();
    tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_cout", res_cout, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_e_res_valid", e_res_valid, 0);
    rst_n = 1'b1;
    tick();

    // 1: basic add, latency of exactly 4 edges after accept
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0FFF; req0_cin = 0;
    res_ready = 1;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    tick(); tick(); tick();
    chk("t1_valid_early", res_valid, 0);
    tick();
    chk("t1_valid_on_time", res_valid, 1);
    take_result("t1", 16'h2233, 1'b0, 1'b0);

    // 2: carry ripples through every nibble
    req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1;
    #1;
    chk("t2_req1_ready", req1_ready, 1);
    chk("t2_req0_ready", req0_ready, 0);
    tick();
    req1_valid = 0;
    take_result("t2", 16'h0000, 1'b1, 1'b1);

    // 3: both requesters continuously valid -> alternate grants
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h0100; req1_b = 16'h0200; req1_cin = 0;
    res_ready = 1;
    grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
      #1;
      chk("t3_one_ready", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) begin
        gseq[grants] = int'(req1_ready);
        grants++;
      end
      tick();
      if (grants == 4) begin
        req0_valid = 0;
        req1_valid = 0;
      end
    end
    chk("t3_grant_count", grants, 4);
    chk("t3_grant0", gseq[0], 0);
    chk("t3_grant1", gseq[1], 1);
    chk("t3_grant2", gseq[2], 0);
    chk("t3_grant3", gseq[3], 1);
    take_result("t3", 16'h0300, 1'b0, 1'b1);

    // 4: backpressure holds the result and blocks new accepts
    res_ready = 0;
    req0_valid = 1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 0;
    #1;
    chk("t4_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    wait_res("t4", 20);
    req1_valid = 1; req1_a = 16'h0005; req1_b = 16'h0006; req1_cin = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_sum", res_sum, 16'hBCDE);
      chk("t4_hold_cout", res_cout, 0);
      chk("t4_hold_id", res_id, 0);
      chk("t4_no_ready", req0_ready | req1_ready, 0);
      tick();
    end
    res_ready = 1;
    #1;
    chk("t4_valid_before_take", res_valid, 1);
    tick();
    chk("t4_valid_after_take", res_valid, 0);
    chk("t4_idle_req1_ready", req1_ready, 1);
    req1_valid = 0;
    #1;

    // 5: reset mid-RUN abandons the op; next tie goes to req0
    req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
    #1;
    chk("t5_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t5_rst_valid", res_valid, 0);
    chk("t5_rst_sum", res_sum, 0);
    chk("t5_rst_cout", res_cout, 0);
    req0_valid = 1; req0_a = 16'h0F0F; req0_b = 16'hF0F0; req0_cin = 1;
    req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0004; req1_cin = 0;
    #1;
    chk("t5_tie_req0_ready", req0_ready, 1);
    chk("t5_tie_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    take_result("t5", 16'h0000, 1'b1, 1'b0);
    chk("t5_no_extra_result", res_valid, 0);

    // 6: WIDTH=8 random traffic from both requesters with random backpressure
    done6 = 0;
    e_exp = '0;
    e_exp_id = 0;
    for (int cyc = 0; cyc < 20000 && done6 < 500; cyc++) begin
      if (!e0_valid && $urandom_range(0, 1) == 1) begin
        e0_valid = 1; e0_a = 8'($urandom); e0_b = 8'($urandom); e0_cin = 1'($urandom);
      end
      if (!e1_valid && $urandom_range(0, 1) == 1) begin
        e1_valid = 1; e1_a = 8'($urandom); e1_b = 8'($urandom); e1_cin = 1'($urandom);
      end
      e_res_ready = 1'($urandom_range(0, 1));
      #1;
      acc0 = e0_ready;
      acc1 = e1_ready;
      if (acc0 && acc1) chk("t6_one_ready", {acc0, acc1}, 2'b00);
      if (acc0) begin
        e_exp = {1'b0, e0_a} + {1'b0, e0_b} + {8'b0, e0_cin};
        e_exp_id = 0;
      end
      if (acc1) begin
        e_exp = {1'b0, e1_a} + {1'b0, e1_b} + {8'b0, e1_cin};
        e_exp_id = 1;
      end
      if (e_res_valid && e_res_ready) begin
        chk("t6_sum", {e_res_cout, e_res_sum}, e_exp);
        chk("t6_id", e_res_id, e_exp_id);
        done6++;
      end
      tick();
      if (acc0) e0_valid = 0;
      if (acc1) e1_valid = 0;
    end
    chk("t6_result_count", done6, 500);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
